// File: rtl/i2c_reg_controller.sv
// i2c_reg_controller
// Turns the byte-level event stream of an I2C slave into accesses on a small
// register file. The file is shared with internal FPGA logic, which writes it
// through the int_wr_* port.
//
// The first byte after a START sets the register pointer. Each later received
// byte is written to reg[ptr]. Each TX request returns reg[ptr]. The pointer
// auto-increments and wraps after every access.
//
// Ports:
//   sclk, rst                  clock, async active-high reset
//   i2c_start/stop             1-cycle bus condition pulses
//   i2c_rx_valid/rx_data       received byte
//   i2c_tx_req                 slave asks for the next TX byte
//   i2c_tx_data/tx_valid       TX byte, valid 1 cycle after the request
//   int_wr_en/addr/data/ack    internal write, held until acked (ack is combinational)
//   reg_flat                   register file, reg i at [8i+7:8i]
//   cmd_strobe                 per-register pulse the cycle after an I2C write
//   busy                       transaction open
//   timeout                    pulse when an idle transaction is aborted
//
// Optional macro I2C_REG_STATUS_CLEAR_EN: register NUM_REGS-1 becomes
// clear-on-read and ignores I2C writes.
module i2c_reg_controller #(
    parameter int NUM_REGS       = 16,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int AW            = $clog2(NUM_REGS)
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  i2c_start,
    input  logic                  i2c_stop,
    input  logic                  i2c_rx_valid,
    input  logic [7:0]            i2c_rx_data,
    input  logic                  i2c_tx_req,
    output logic [7:0]            i2c_tx_data,
    output logic                  i2c_tx_valid,
    input  logic                  int_wr_en,
    input  logic [AW-1:0]         int_wr_addr,
    input  logic [7:0]            int_wr_data,
    output logic                  int_wr_ack,
    output logic [8*NUM_REGS-1:0] reg_flat,
    output logic [NUM_REGS-1:0]   cmd_strobe,
    output logic                  busy,
    output logic                  timeout
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);
`ifdef I2C_REG_STATUS_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                       state_q, state_d;
    logic [AW-1:0]                ptr_q, ptr_d;
    logic [NUM_REGS-1:0][7:0]     regs_q, regs_d;
    logic [7:0]                   tx_data_q, tx_data_d;
    logic                         tx_valid_q, tx_valid_d;
    logic [NUM_REGS-1:0]          strobe_q, strobe_d;
    logic                         timeout_q, timeout_d;
    logic [TW-1:0]                tocnt_q, tocnt_d;
    logic                         clr_q, clr_d;
    logic                         i2c_wr;
    logic                         active;
    logic                         evt;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            regs_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            strobe_q   <= '0;
            timeout_q  <= 1'b0;
            tocnt_q    <= '0;
            clr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            regs_q     <= regs_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            strobe_q   <= strobe_d;
            timeout_q  <= timeout_d;
            tocnt_q    <= tocnt_d;
            clr_q      <= clr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        regs_d     = regs_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        strobe_d   = '0;
        timeout_d  = 1'b0;
        tocnt_d    = tocnt_q;
        clr_d      = 1'b0;
        i2c_wr     = 1'b0;
        int_wr_ack = 1'b0;
        active     = (state_q != IDLE);
        evt        = i2c_start | i2c_stop | i2c_rx_valid | i2c_tx_req;

        if (i2c_rx_valid && state_q == ADDR) begin
            ptr_d   = i2c_rx_data[AW-1:0];
            state_d = DATA;
        end else if (i2c_rx_valid && state_q == DATA) begin
            // A dropped write to the status register does not occupy the
            // write port, so an internal request can still go through.
            if (!(CLR_EN && ptr_q == LAST)) begin
                regs_d[ptr_q]   = i2c_rx_data;
                strobe_d[ptr_q] = 1'b1;
                i2c_wr          = 1'b1;
            end
            ptr_d = ptr_q + 1'b1;
        end

        // regs_q is sampled here, so a same-cycle write is not yet visible.
        if (i2c_tx_req) begin
            tx_valid_d = 1'b1;
            if (active) begin
                tx_data_d = regs_q[ptr_q];
                ptr_d     = ptr_q + 1'b1;
                clr_d     = CLR_EN && (ptr_q == LAST);
            end else begin
                tx_data_d = 8'hFF;
            end
        end

        // The clear is applied before the internal write, so the internal
        // write wins when both hit the status register in the same cycle.
        if (clr_q) regs_d[LAST] = 8'h00;

        if (int_wr_en && !i2c_wr) begin
            regs_d[int_wr_addr] = int_wr_data;
            int_wr_ack          = 1'b1;
        end

        if (!active || evt) begin
            tocnt_d = '0;
        end else if (tocnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tocnt_d   = '0;
            state_d   = IDLE;
            timeout_d = 1'b1;
        end else begin
            tocnt_d = tocnt_q + 1'b1;
        end

        // START is evaluated last so that it wins over a simultaneous STOP.
        if (i2c_stop)  state_d = IDLE;
        if (i2c_start) state_d = ADDR;
    end

    assign i2c_tx_data  = tx_data_q;
    assign i2c_tx_valid = tx_valid_q;
    assign reg_flat     = regs_q;
    assign cmd_strobe   = strobe_q;
    assign busy         = (state_q != IDLE);
    assign timeout      = timeout_q;
endmodule
